// File: rtl/sort_frame_ctrl_if.sv
// Framed ready/valid stream: a data word, its valid, an end-of-frame marker,
// and the backpressure ready.
interface sort_frame_ctrl_if #(
    parameter int DW = 8
);
    logic [DW-1:0] data;
    logic          valid;
    logic          last;
    logic          ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/sort_frame_ctrl.sv
// Frame controller for a DEPTH-stage compare-chain sorter: loads a frame of
// 1..DEPTH words, then drains it out in ascending order with backpressure.
module sort_frame_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sort_frame_ctrl_if.slave  in_s,
    sort_frame_ctrl_if.master out_m,
    output logic [DW-1:0]     sort_in,
    output logic              sort_en,
    output logic              sort_clear,
    input  logic [DW-1:0]     sort_out
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    typedef enum logic [1:0] {CLEAR, LOAD, DRAIN} state_t;

    state_t        state_reg;
    logic [CW-1:0] ld_cnt_reg;
    logic [CW-1:0] dr_cnt_reg;
    logic [CW-1:0] k_reg;
    logic [DW-1:0] out_data_reg;
    logic          out_valid_reg;
    logic          out_last_reg;

    logic          slot_free;
    logic          real_idx;
    logic          advance;
    logic          load_out;
    logic          frame_end;

    assign slot_free = !out_valid_reg || out_m.ready;
    // The first DEPTH-k drain indices eject the zeros left over from the clear.
    assign real_idx  = (dr_cnt_reg >= (DEPTH_C - k_reg));
    assign advance   = (state_reg == DRAIN) && (!real_idx || slot_free);
    assign load_out  = advance && real_idx;
    assign frame_end = in_s.valid && (in_s.last || (ld_cnt_reg == LAST_IDX));

    assign in_s.ready  = (state_reg == LOAD);
    assign out_m.data  = out_data_reg;
    assign out_m.valid = out_valid_reg;
    assign out_m.last  = out_last_reg;

    always_comb begin
        sort_in    = '0;
        sort_en    = 1'b0;
        sort_clear = 1'b0;
        case (state_reg)
            CLEAR: sort_clear = 1'b1;
            LOAD: begin
                sort_in = in_s.data;
                sort_en = in_s.valid;
            end
            DRAIN: begin
                // Max sentinel pushes the smallest held value out each advance.
                sort_in    = '1;
                sort_en    = advance;
                sort_clear = advance && (dr_cnt_reg == LAST_IDX);
            end
            default: sort_clear = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= CLEAR;
            ld_cnt_reg    <= '0;
            dr_cnt_reg    <= '0;
            k_reg         <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            if (load_out) begin
                out_data_reg  <= sort_out;
                out_valid_reg <= 1'b1;
                out_last_reg  <= (dr_cnt_reg == LAST_IDX);
            end else if (out_valid_reg && out_m.ready) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                CLEAR: state_reg <= LOAD;
                LOAD: begin
                    if (frame_end) begin
                        k_reg      <= ld_cnt_reg + 1'b1;
                        ld_cnt_reg <= '0;
                        dr_cnt_reg <= '0;
                        state_reg  <= DRAIN;
                    end else if (in_s.valid) begin
                        ld_cnt_reg <= ld_cnt_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    if (advance) begin
                        if (dr_cnt_reg == LAST_IDX) begin
                            dr_cnt_reg <= '0;
                            state_reg  <= LOAD;
                        end else begin
                            dr_cnt_reg <= dr_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Bench for sort_frame_ctrl: behavioural compare-chain sorter, table of frames
// with expected sorted output on a scoreboard, plus a mid-drain reset sequence.
module tb_sort_frame_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] sort_in;
    logic          sort_en;
    logic          sort_clear;
    logic [DW-1:0] sort_out;

    sort_frame_ctrl_if #(.DW(DW)) in_if ();
    sort_frame_ctrl_if #(.DW(DW)) out_if ();

    sort_frame_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_s       (in_if),
        .out_m      (out_if),
        .sort_in    (sort_in),
        .sort_en    (sort_en),
        .sort_clear (sort_clear),
        .sort_out   (sort_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sorter model: holds a multiset of DEPTH values; each advance inserts
    // sort_in and ejects the minimum of held values and sort_in.
    logic [DW-1:0] sreg [DEPTH];
    int            smin_idx;
    logic          pass_in;

    always_comb begin
        smin_idx = 0;
        for (int i = 1; i < DEPTH; i++)
            if (sreg[i] < sreg[smin_idx]) smin_idx = i;
        pass_in  = (sort_in <= sreg[smin_idx]);
        sort_out = pass_in ? sort_in : sreg[smin_idx];
    end

    always_ff @(posedge clk) begin
        if (sort_clear) begin
            for (int i = 0; i < DEPTH; i++) sreg[i] <= '0;
        end else if (sort_en && !pass_in) begin
            sreg[smin_idx] <= sort_in;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [DW:0] sb [$];
    bit bp_mode = 1'b0;

    // Downstream ready: held high, or random when backpressure is enabled.
    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_if.ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic          prev_v, prev_r, prev_l;
    logic [DW-1:0] prev_d;
    logic [DW:0]   exp_beat;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                checks++;
                if (!(out_if.valid && out_if.data == prev_d && out_if.last == prev_l)) begin
                    errors++;
                    $display("FAIL hold: got v=%0b d=%0d l=%0b, required v=1 d=%0d l=%0b",
                             out_if.valid, out_if.data, out_if.last, prev_d, prev_l);
                end
            end
            if (out_if.valid && out_if.ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected beat d=%0d l=%0b, none required",
                             out_if.data, out_if.last);
                end else begin
                    exp_beat = sb.pop_front();
                    if ({out_if.last, out_if.data} !== exp_beat) begin
                        errors++;
                        $display("FAIL beat: got d=%0d l=%0b, required d=%0d l=%0b",
                                 out_if.data, out_if.last, exp_beat[DW-1:0], exp_beat[DW]);
                    end else begin
                        $display("beat d=%0d l=%0b ok", out_if.data, out_if.last);
                    end
                end
            end
            prev_v = out_if.valid;
            prev_r = out_if.ready;
            prev_d = out_if.data;
            prev_l = out_if.last;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic drive_word(input logic [DW-1:0] d, input logic l);
        int t = 0;
        in_if.data  = d;
        in_if.valid = 1'b1;
        in_if.last  = l;
        forever begin
            @(negedge clk);
            if (in_if.ready) break;
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL accept: word %0d not accepted within 200 cycles", d);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained();
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_done_pending", 32'(sb.size()), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [6*DW-1:0] w;
        int              n;
        logic [5:0]      lm;
        logic [6*DW-1:0] e;
        int              ne;
        logic [5:0]      el;
        bit              bp;
        bit              chk_drain;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [6*DW-1:0] pack6(input logic [DW-1:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    initial begin
        vecs[0] = '{pack6(7, 3, 9, 1, 0, 0), 4, 6'b001000,
                    pack6(1, 3, 7, 9, 0, 0), 4, 6'b001000, 1'b0, 1'b1};
        vecs[1] = '{pack6(5, 2, 0, 0, 0, 0), 2, 6'b000010,
                    pack6(2, 5, 0, 0, 0, 0), 2, 6'b000010, 1'b0, 1'b1};
        vecs[2] = '{pack6(255, 0, 255, 0, 0, 0), 4, 6'b001000,
                    pack6(0, 0, 255, 255, 0, 0), 4, 6'b001000, 1'b0, 1'b1};
        vecs[3] = '{pack6(4, 4, 0, 0, 0, 0), 2, 6'b000010,
                    pack6(4, 4, 0, 0, 0, 0), 2, 6'b000010, 1'b0, 1'b1};
        vecs[4] = '{pack6(8, 6, 2, 4, 0, 0), 4, 6'b001000,
                    pack6(2, 4, 6, 8, 0, 0), 4, 6'b001000, 1'b1, 1'b0};
        vecs[5] = '{pack6(10, 40, 30, 20, 60, 50), 6, 6'b100000,
                    pack6(10, 20, 30, 40, 50, 60), 6, 6'b101000, 1'b0, 1'b0};

        rst_n        = 1'b0;
        in_if.data   = '0;
        in_if.valid  = 1'b0;
        in_if.last   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",   32'(in_if.ready),   0);
        check("rst_out_valid",  32'(out_if.valid),  0);
        check("rst_out_data",   32'(out_if.data),   0);
        check("rst_out_last",   32'(out_if.last),   0);
        check("rst_sort_en",    32'(sort_en),       0);
        check("rst_sort_clear", 32'(sort_clear),    1);
        check("rst_sort_in",    32'(sort_in),       0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            int cnt;
            $display("frame %0d: %0d words, backpressure=%0b", v, vecs[v].n, vecs[v].bp);
            bp_mode = vecs[v].bp;
            for (int i = 0; i < vecs[v].ne; i++)
                sb.push_back({vecs[v].el[i], vecs[v].e[i*DW +: DW]});
            for (int i = 0; i < vecs[v].n; i++)
                drive_word(vecs[v].w[i*DW +: DW], vecs[v].lm[i]);
            in_if.valid = 1'b0;
            in_if.last  = 1'b0;
            if (vecs[v].chk_drain) begin
                cnt = 0;
                forever begin
                    @(negedge clk);
                    if (in_if.ready || cnt > 50) break;
                    cnt++;
                end
                check("drain_cycles", 32'(cnt), DEPTH);
            end
            wait_drained();
            bp_mode = 1'b0;
        end

        // Reset in the middle of a drain, right after the first beat leaves.
        $display("frame reset: 4 words, reset after first beat");
        begin
            int t = 0;
            sb.push_back({1'b0, 8'd1});
            sb.push_back({1'b0, 8'd3});
            sb.push_back({1'b0, 8'd7});
            sb.push_back({1'b1, 8'd9});
            drive_word(7, 0);
            drive_word(3, 0);
            drive_word(9, 0);
            drive_word(1, 1);
            in_if.valid = 1'b0;
            in_if.last  = 1'b0;
            while (sb.size() != 3 && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("mid_first_beat_popped", 32'(sb.size()), 3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_out_valid",  32'(out_if.valid), 0);
        check("mid_rst_sort_clear", 32'(sort_clear),   1);
        check("mid_rst_in_ready",   32'(in_if.ready),  0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rel_sort_clear", 32'(sort_clear), 1);
        @(posedge clk);
        #1;
        check("load_sort_clear", 32'(sort_clear),  0);
        check("load_in_ready",   32'(in_if.ready), 1);

        $display("frame post-reset: 2 words");
        sb.push_back({1'b0, 8'd1});
        sb.push_back({1'b1, 8'd3});
        drive_word(3, 0);
        drive_word(1, 1);
        in_if.valid = 1'b0;
        in_if.last  = 1'b0;
        wait_drained();

        check("final_out_valid", 32'(out_if.valid), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sort_frame_ctrl.md
# sort_frame_ctrl

Frame controller for the DEPTH-stage compare-chain sorter: accepts a ready/valid stream, cuts it into frames of 1..DEPTH words, loads each frame into the sorter, then drains it out in ascending order as a framed ready/valid stream. It owns the sorter's insert input, its advance enable and its clear. Frames do not overlap; each frame is drained completely before the next is loaded.

## Interface
- DW, 8: data width.
- DEPTH, 4: sorter stages (max frame length), ≥2; counters are $clog2(DEPTH+1) bits wide.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  DW  input word.
- in_valid  in  1  input word present.
- in_last  in  1  word is last of frame (qualified by in_valid).
- in_ready  out  1  controller accepts input.
- out_data  out  DW  sorted word, registered.
- out_valid  out  1  out_data valid, registered.
- out_last  out  1  last word of frame, registered.
- out_ready  in  1  downstream accepts.
- sort_in  out  DW  word inserted into sorter chain.
- sort_en  out  1  sorter registers update this cycle.
- sort_clear  out  1  sorter registers load 0 this cycle (overrides sort_en).
- sort_out  in  DW  sorter min output (combinational from sort_in and sorter registers).

## Operation
- States: CLEAR, LOAD, DRAIN. Reset state CLEAR.
- CLEAR: sort_clear=1, sort_en=0, sort_in=0, in_ready=0; next LOAD. Entered only from reset.
- LOAD: in_ready=1; sort_in=in_data; sort_en=in_valid. Each accepted word increments ld_cnt (reset 0). If in_last or ld_cnt==DEPTH-1 on acceptance: store k=ld_cnt+1, clear ld_cnt and dr_cnt, go DRAIN. More than DEPTH words with no in_last: frame forcibly closed at DEPTH; the next word starts a new frame.
- DRAIN: in_ready=0; sort_in = all-ones (max sentinel), so each advance ejects the current smallest held value on sort_out.
  - Advance index dr_cnt 0..DEPTH-1. Indices < DEPTH-k are zero fillers from clear: suppressed, advance unconditionally (sort_en=1), no output load.
  - Indices ≥ DEPTH-k: advance only when output slot free (!out_valid || out_ready); on advance, load out_data=sort_out, out_valid=1, out_last=(dr_cnt==DEPTH-1).
  - Advance at dr_cnt==DEPTH-1: also sort_clear=1 (clear wins), go LOAD.
- Output register: out_valid clears when out_valid && out_ready and no new load in the same cycle; simultaneous consume+load keeps out_valid=1 with new data.
- Data values 0 and all-ones are legal; ties sort stably by value (identical words, order immaterial).

## Timing
- Reset values: state CLEAR, in_ready 0, out_valid 0, out_data 0, out_last 0, sort_en 0, sort_clear 1 (combinational from CLEAR), sort_in 0, counters 0.
- Reset is asynchronous at any point, including mid-LOAD/mid-DRAIN: partial frame and pending output discarded; first cycle after release is CLEAR.
- in_ready combinational from state only (no dependence on in_valid).
- Frame of k words, out_ready held 1: k LOAD cycles (with in_valid held), then DEPTH DRAIN cycles; first output out_valid rises the cycle after the first non-suppressed drain advance; last word out_last=1.
- Throughput with out_ready=1 and in_valid held: DEPTH+k cycles per frame; the first word of the next frame is accepted the cycle after the last drain advance.
- out_ready low: out_data/out_valid/out_last held stable; sorter does not advance on non-suppressed indices.

## Test plan
- Full frame: 7,3,9,1 (in_last on 1), out_ready=1 -> out 1,3,7,9, out_last only on 9; in_ready returns 1 after 4 DRAIN cycles.
- Short frame: 5,2 with in_last on 2 -> exactly two beats 2,5, out_last on 5; no zero fillers emitted.
- Extremes/duplicates (DW=8): 255,0,255,0 -> 0,0,255,255; next frame 4,4 -> 4,4 (no all-ones sentinel leakage).
- Backpressure: frame 8,6,2,4 with out_ready toggling randomly -> 2,4,6,8 each held stable while out_ready=0; no loss or duplication.
- Overlong stream: 6 words 10,40,30,20,60,50 with in_last only on 50 -> frames 10,20,30,40 (out_last on 40) then 50,60 (out_last on 60).
- Reset mid-DRAIN after first output: out_valid=0 immediately, sort_clear=1 while rst_n low and for the cycle after release; new frame 3,1 -> 1,3.
